// File: rtl/oka_overlap_accum.sv
// oka_overlap_accum: pipelined overlap-free Karatsuba recombiner with GF(2) multiply-accumulate
module oka_overlap_accum #(
    parameter int N  = 16,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-2:0]    p_ee,
    input  logic [N-2:0]    p_eo,
    input  logic [N-2:0]    p_oe,
    input  logic [N-2:0]    p_oo,
    input  logic            acc_first,
    input  logic            acc_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*N-2:0]  out_data,
    output logic [CW-1:0]   out_cnt,
    output logic            acc_drop
);
    logic           r_s1_valid, r_s1_first, r_s1_last, r_acc_open;
    logic [N-2:0]   r_ee, r_eo, r_oe, r_oo;
    logic [2*N-2:0] r_acc, w_c, w_acc_next;
    logic [CW-1:0]  r_cnt, w_cnt_next;
    logic [N-1:0]   w_ev_lo, w_ev_hi;
    logic           w_s1_adv, w_restart;
    // only a last transaction must wait for the output register to free up
    assign w_s1_adv  = r_s1_valid && (!r_s1_last || !out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_restart = r_s1_first || !r_acc_open;
    assign w_ev_lo   = {1'b0, r_ee};
    assign w_ev_hi   = {r_oo, 1'b0};
    always_comb begin
        w_c = '0;
        for (int k = 0; k < N; k++) w_c[2*k] = w_ev_lo[k] ^ w_ev_hi[k];
        for (int k = 0; k < N-1; k++) w_c[2*k+1] = r_eo[k] ^ r_oe[k];
    end
    assign w_acc_next = w_restart ? w_c : r_acc ^ w_c;
    assign w_cnt_next = w_restart ? CW'(1) : (&r_cnt ? r_cnt : r_cnt + 1'b1);
    assign acc_drop   = w_s1_adv && r_s1_first && r_acc_open && !rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_ee       <= '0;
            r_eo       <= '0;
            r_oe       <= '0;
            r_oo       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_acc_open <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_cnt    <= '0;
        end else begin
            if (in_valid && in_ready) begin
                r_s1_valid <= 1'b1;
                r_s1_first <= acc_first;
                r_s1_last  <= acc_last;
                r_ee       <= p_ee;
                r_eo       <= p_eo;
                r_oe       <= p_oe;
                r_oo       <= p_oo;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s1_adv && r_s1_last) begin
                out_valid  <= 1'b1;
                out_data   <= w_acc_next;
                out_cnt    <= w_cnt_next;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_acc_open <= 1'b0;
            end else begin
                if (out_valid && out_ready) out_valid <= 1'b0;
                if (w_s1_adv) begin
                    r_acc      <= w_acc_next;
                    r_cnt      <= w_cnt_next;
                    r_acc_open <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_oka_overlap_accum.sv
// tb_oka_overlap_accum: directed and random checks of the recombiner against a transaction-level GF(2) model
module tb_oka_overlap_accum;
    logic        clk, rst, in_valid, in_ready, acc_first, acc_last;
    logic        out_valid, out_ready, acc_drop;
    logic [6:0]  p_ee, p_eo, p_oe, p_oo;
    logic [14:0] out_data;
    logic [7:0]  out_cnt;
    logic        in_ready2, out_valid2, acc_drop2;
    logic [14:0] out_data2;
    logic [1:0]  out_cnt2;

    oka_overlap_accum #(.N(8), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p_ee(p_ee), .p_eo(p_eo), .p_oe(p_oe), .p_oo(p_oo),
        .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_cnt(out_cnt), .acc_drop(acc_drop)
    );
    oka_overlap_accum #(.N(8), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .p_ee(p_ee), .p_eo(p_eo), .p_oe(p_oe), .p_oo(p_oo),
        .acc_first(acc_first), .acc_last(acc_last),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_cnt(out_cnt2), .acc_drop(acc_drop2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] d;
        logic [7:0]  c8;
        logic [1:0]  c2;
    } exp_t;
    exp_t q[$];
    int n_tests = 0, n_fail = 0, n_out = 0;
    int drops_seen = 0, drops_seen2 = 0, drops_exp = 0;
    logic [14:0] m_acc = '0;
    logic [7:0]  m_c8 = '0;
    logic [1:0]  m_c2 = '0;
    logic        m_open = 1'b0;
    logic        rnd_ready = 1'b0;

    function automatic logic [14:0] spread(input logic [6:0] x);
        logic [14:0] r = '0;
        for (int i = 0; i < 7; i++) r[2*i] = x[i];
        return r;
    endfunction

    function automatic logic [14:0] recomb(input logic [6:0] ee, eo, oe, oo);
        return spread(ee) ^ (spread(oo) << 2) ^ ((spread(eo) ^ spread(oe)) << 1);
    endfunction

    function automatic logic [14:0] clmul8(input logic [7:0] a, b);
        logic [14:0] r = '0;
        for (int i = 0; i < 8; i++) if (b[i]) r ^= 15'(a) << i;
        return r;
    endfunction

    function automatic logic [6:0] clmul4(input logic [3:0] a, b);
        logic [6:0] r = '0;
        for (int i = 0; i < 4; i++) if (b[i]) r ^= 7'(a) << i;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [6:0] ee, eo, oe, oo, input logic f, l, input logic [14:0] c);
        bit ok = 0;
        exp_t e;
        p_ee = ee; p_eo = eo; p_oe = oe; p_oo = oo;
        acc_first = f; acc_last = l; in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom % 3) != 0;
        end
        chk("accept", 32'(ok), 1);
        if (ok) begin
            if (f || !m_open) begin
                if (f && m_open) drops_exp++;
                m_acc = c; m_c8 = 8'd1; m_c2 = 2'd1;
            end else begin
                m_acc ^= c;
                m_c8 = (m_c8 == 8'hFF) ? m_c8 : m_c8 + 8'd1;
                m_c2 = (m_c2 == 2'd3) ? m_c2 : m_c2 + 2'd1;
            end
            if (l) begin
                e.d = m_acc; e.c8 = m_c8; e.c2 = m_c2;
                q.push_back(e);
                m_open = 1'b0;
            end else begin
                m_open = 1'b1;
            end
        end
    endtask

    task automatic expect_out(input string tag, input logic [14:0] d, input logic [7:0] c8, input logic [1:0] c2);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk({tag, "_valid"}, 32'(seen), 1);
        chk({tag, "_data"}, 32'(out_data), 32'(d));
        chk({tag, "_cnt"}, 32'(out_cnt), 32'(c8));
        chk({tag, "_cnt2"}, 32'(out_cnt2), 32'(c2));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (acc_drop) drops_seen++;
        if (acc_drop2) drops_seen2++;
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            n_out++;
            if (q.size() == 0) begin
                chk("spurious_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e.d));
                chk("sb_cnt", 32'(out_cnt), 32'(e.c8));
                chk("sb_data2", 32'({out_valid2, out_data2}), 32'({1'b1, e.d}));
                chk("sb_cnt2", 32'(out_cnt2), 32'(e.c2));
            end
        end
    end

    initial begin
        int n0, d0;
        logic [14:0] x;
        logic [7:0] a, b;
        logic [3:0] ae, ao, be, bo;
        logic f, l;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        acc_first = 1'b0; acc_last = 1'b0;
        p_ee = '0; p_eo = '0; p_oe = '0; p_oo = '0;
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'({in_ready, in_ready2}), 32'h3);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_cnt", 32'(out_cnt), 0);
        chk("rst_acc_drop", 32'(acc_drop), 0);
        @(posedge clk);
        #1;

        send(7'h01, 7'h01, 7'h01, 7'h01, 1, 1, recomb(7'h01, 7'h01, 7'h01, 7'h01));
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1", 32'(out_valid), 0);
        @(negedge clk);
        chk("lat_t2", 32'(out_valid), 1);
        chk("a3b3_data", 32'(out_data), 32'h0005);
        chk("a3b3_cnt", 32'(out_cnt), 1);
        @(posedge clk);
        #1;

        send(7'h7F, 7'h00, 7'h00, 7'h7F, 1, 1, recomb(7'h7F, 7'h00, 7'h00, 7'h7F));
        in_valid = 1'b0;
        expect_out("ee_oo", 15'h4001, 8'd1, 2'd1);
        send(7'h00, 7'h7F, 7'h00, 7'h00, 1, 1, recomb(7'h00, 7'h7F, 7'h00, 7'h00));
        in_valid = 1'b0;
        expect_out("eo", 15'h2AAA, 8'd1, 2'd1);
        send(7'h00, 7'h00, 7'h00, 7'h40, 1, 1, recomb(7'h00, 7'h00, 7'h00, 7'h40));
        in_valid = 1'b0;
        expect_out("oo_top", 15'h4000, 8'd1, 2'd1);

        n0 = n_out;
        send(7'h01, 7'h00, 7'h00, 7'h00, 1, 0, recomb(7'h01, 7'h00, 7'h00, 7'h00));
        send(7'h03, 7'h00, 7'h00, 7'h00, 0, 1, recomb(7'h03, 7'h00, 7'h00, 7'h00));
        in_valid = 1'b0;
        expect_out("acc2", 15'h0004, 8'd2, 2'd2);
        cyc(3);
        chk("acc_one_out", 32'(n_out - n0), 1);

        out_ready = 1'b0;
        send(7'h11, 7'h00, 7'h00, 7'h00, 1, 1, recomb(7'h11, 7'h00, 7'h00, 7'h00));
        send(7'h22, 7'h00, 7'h00, 7'h00, 1, 1, recomb(7'h22, 7'h00, 7'h00, 7'h00));
        p_ee = 7'h33;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_hold", 32'({out_valid, out_data}), 32'({1'b1, recomb(7'h11, 7'h00, 7'h00, 7'h00)}));
            @(posedge clk);
            #1;
        end
        n0 = n_out;
        out_ready = 1'b1;
        send(7'h33, 7'h00, 7'h00, 7'h00, 1, 1, recomb(7'h33, 7'h00, 7'h00, 7'h00));
        in_valid = 1'b0;
        cyc(6);
        chk("bp_all_out", 32'(n_out - n0), 3);

        d0 = drops_seen;
        send(7'h01, 7'h00, 7'h00, 7'h00, 1, 0, recomb(7'h01, 7'h00, 7'h00, 7'h00));
        send(7'h02, 7'h00, 7'h00, 7'h00, 1, 1, recomb(7'h02, 7'h00, 7'h00, 7'h00));
        in_valid = 1'b0;
        expect_out("drop", 15'h0004, 8'd1, 2'd1);
        chk("drop_once", 32'(drops_seen - d0), 1);

        x = '0;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom);
            x ^= recomb(a[6:0], 7'h00, 7'h00, 7'h00);
            send(a[6:0], 7'h00, 7'h00, 7'h00, i == 0, i == 4, recomb(a[6:0], 7'h00, 7'h00, 7'h00));
        end
        in_valid = 1'b0;
        expect_out("sat", x, 8'd5, 2'd3);

        out_ready = 1'b0;
        send(7'h05, 7'h00, 7'h00, 7'h00, 1, 1, recomb(7'h05, 7'h00, 7'h00, 7'h00));
        send(7'h06, 7'h00, 7'h00, 7'h00, 1, 0, recomb(7'h06, 7'h00, 7'h00, 7'h00));
        in_valid = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        d0 = drops_seen;
        rst = 1'b1;
        q.delete();
        m_open = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 0);
        chk("post_rst_cnt", 32'(out_cnt), 0);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_nodrop", 32'(drops_seen - d0), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(7'h01, 7'h00, 7'h00, 7'h00, 0, 1, recomb(7'h01, 7'h00, 7'h00, 7'h00));
        in_valid = 1'b0;
        expect_out("after_rst", 15'h0001, 8'd1, 2'd1);

        rnd_ready = 1'b1;
        for (int t = 0; t < 150; t++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            ae = {a[6], a[4], a[2], a[0]}; ao = {a[7], a[5], a[3], a[1]};
            be = {b[6], b[4], b[2], b[0]}; bo = {b[7], b[5], b[3], b[1]};
            f = ($urandom % 4) == 0;
            l = ($urandom % 3) == 0;
            send(clmul4(ae, be), clmul4(ae, bo), clmul4(ao, be), clmul4(ao, bo), f, l, clmul8(a, b));
            if (($urandom % 4) == 0) begin
                in_valid = 1'b0;
                cyc(1);
            end
        end
        in_valid = 1'b0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) cyc(1);
        cyc(2);
        chk("end_queue_empty", 32'(q.size()), 0);
        chk("end_drops", 32'(drops_seen), 32'(drops_exp));
        chk("end_drops2", 32'(drops_seen2), 32'(drops_exp));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
